// File: rtl/mc_parser_pkg.sv
// Shared types and header layout for the memcached binary request parser.
// Field offsets are byte positions inside each 64-bit header beat.
package mc_parser_pkg;

    localparam logic [7:0] MAGIC_DEF = 8'h80;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        HDR2,
        BODY,
        DROP
    } stateT;

    // beat 0
    localparam int OFF_MAGIC    = 0;
    localparam int OFF_OPCODE   = 1;
    localparam int OFF_KEY_LEN  = 2;
    localparam int OFF_EXT_LEN  = 4;
    // beat 1
    localparam int OFF_BODY_LEN = 0;
    localparam int OFF_OPAQUE   = 4;
    // beat 2
    localparam int OFF_CAS      = 0;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] keyLen;
        logic [7:0]  extLen;
        logic [31:0] bodyLen;
        logic [31:0] opaque;
        logic [63:0] cas;
    } metaT;

    function automatic logic [7:0] getByte(input logic [63:0] d, input int idx);
        return d[8*idx +: 8];
    endfunction

    // Wire fields are big-endian: lowest byte offset is the most significant.
    function automatic logic [15:0] be16(input logic [63:0] d, input int off);
        return {getByte(d, off), getByte(d, off + 1)};
    endfunction

    function automatic logic [31:0] be32(input logic [63:0] d, input int off);
        return {be16(d, off), be16(d, off + 2)};
    endfunction

    function automatic logic [63:0] be64(input logic [63:0] d);
        return {be32(d, 0), be32(d, 4)};
    endfunction

endpackage

// File: rtl/mc_bin_req_parser_sat_counter.sv
// Saturating event counter; sticks at all-ones once reached.
// Used for the parser's packet, drop and length-error statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         apclk,
    input  logic         apresetn,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Count up on inc until all-ones.
    always_ff @(posedge apclk or negedge apresetn) begin
        if (!apresetn) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/mc_bin_req_parser.sv
// Memcached binary request header parser with body pass-through.
// Optional body length checking is enabled by MC_PARSER_LEN_CHECK_EN.
module mc_bin_req_parser
    import mc_parser_pkg::*;
#(
    parameter logic [7:0] MAGIC = MAGIC_DEF,
    parameter int         CNT_W = 16
) (
    input  logic             apclk,
    input  logic             apresetn,
    input  logic [63:0]      in_axis_tdata,
    input  logic [7:0]       in_axis_tkeep,
    input  logic [63:0]      in_axis_tuser,
    input  logic             in_axis_tlast,
    input  logic             in_axis_tvalid,
    output logic             in_axis_tready,
    output logic [7:0]       meta_opcode,
    output logic [15:0]      meta_key_len,
    output logic [7:0]       meta_ext_len,
    output logic [31:0]      meta_body_len,
    output logic [31:0]      meta_opaque,
    output logic [63:0]      meta_cas,
    output logic             meta_valid,
    input  logic             meta_ready,
    output logic [63:0]      body_axis_tdata,
    output logic [7:0]       body_axis_tkeep,
    output logic [63:0]      body_axis_tuser,
    output logic             body_axis_tlast,
    output logic             body_axis_tvalid,
    input  logic             body_axis_tready,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] len_err_cnt
);

    stateT state;
    stateT stateNext;
    metaT  meta;
    logic  metaValid;
    logic  beat;
    logic  isBody;
    logic  magicOk;
    logic  latch0;
    logic  latch1;
    logic  latch2;
    logic  pktInc;
    logic  dropInc;

    assign isBody  = (state == BODY);
    assign magicOk = (getByte(in_axis_tdata, OFF_MAGIC) == MAGIC);
    assign beat    = in_axis_tvalid & in_axis_tready;

    // Header beats are always taken, except while a meta word is stuck.
    always_comb begin
        in_axis_tready = 1'b1;
        if (state == HDR0) begin
            in_axis_tready = ~metaValid | meta_ready;
        end else if (isBody) begin
            in_axis_tready = body_axis_tready;
        end
    end

    // Body is a straight wire while in BODY, zero otherwise.
    always_comb begin
        body_axis_tdata  = isBody ? in_axis_tdata : '0;
        body_axis_tkeep  = isBody ? in_axis_tkeep : '0;
        body_axis_tuser  = isBody ? in_axis_tuser : '0;
        body_axis_tlast  = isBody & in_axis_tlast;
        body_axis_tvalid = isBody & in_axis_tvalid;
    end

    // Next-state, field latch strobes and counter events.
    always_comb begin
        stateNext = state;
        latch0    = 1'b0;
        latch1    = 1'b0;
        latch2    = 1'b0;
        pktInc    = 1'b0;
        dropInc   = 1'b0;
        unique case (state)
            HDR0: begin
                if (beat) begin
                    if (!magicOk) begin
                        dropInc   = 1'b1;
                        stateNext = in_axis_tlast ? HDR0 : DROP;
                    end else if (in_axis_tlast) begin
                        dropInc = 1'b1;
                    end else begin
                        latch0    = 1'b1;
                        stateNext = HDR1;
                    end
                end
            end
            HDR1: begin
                if (beat) begin
                    if (in_axis_tlast) begin
                        dropInc   = 1'b1;
                        stateNext = HDR0;
                    end else begin
                        latch1    = 1'b1;
                        stateNext = HDR2;
                    end
                end
            end
            HDR2: begin
                if (beat) begin
                    latch2    = 1'b1;
                    pktInc    = 1'b1;
                    stateNext = in_axis_tlast ? HDR0 : BODY;
                end
            end
            BODY, DROP: begin
                if (beat && in_axis_tlast) begin
                    stateNext = HDR0;
                end
            end
            default: stateNext = HDR0;
        endcase
    end

    // State register.
    always_ff @(posedge apclk or negedge apresetn) begin
        if (!apresetn) begin
            state <= HDR0;
        end else begin
            state <= stateNext;
        end
    end

    // Header fields build up beat by beat; valid rises after the cas beat.
    always_ff @(posedge apclk or negedge apresetn) begin
        if (!apresetn) begin
            meta      <= '0;
            metaValid <= 1'b0;
        end else begin
            if (latch0) begin
                meta.opcode <= getByte(in_axis_tdata, OFF_OPCODE);
                meta.keyLen <= be16(in_axis_tdata, OFF_KEY_LEN);
                meta.extLen <= getByte(in_axis_tdata, OFF_EXT_LEN);
            end
            if (latch1) begin
                meta.bodyLen <= be32(in_axis_tdata, OFF_BODY_LEN);
                meta.opaque  <= be32(in_axis_tdata, OFF_OPAQUE);
            end
            if (metaValid && meta_ready) begin
                metaValid <= 1'b0;
            end
            if (latch2) begin
                meta.cas  <= be64(in_axis_tdata >> (8 * OFF_CAS));
                metaValid <= 1'b1;
            end
        end
    end

    assign meta_opcode   = meta.opcode;
    assign meta_key_len  = meta.keyLen;
    assign meta_ext_len  = meta.extLen;
    assign meta_body_len = meta.bodyLen;
    assign meta_opaque   = meta.opaque;
    assign meta_cas      = meta.cas;
    assign meta_valid    = metaValid;

    sat_counter #(.W(CNT_W)) uPktCnt (
        .apclk    (apclk),
        .apresetn (apresetn),
        .inc      (pktInc),
        .value    (pkt_cnt)
    );

    sat_counter #(.W(CNT_W)) uDropCnt (
        .apclk    (apclk),
        .apresetn (apresetn),
        .inc      (dropInc),
        .value    (drop_cnt)
    );

`ifdef MC_PARSER_LEN_CHECK_EN
    logic [31:0] byteCnt;
    logic [31:0] byteSum;
    logic        lenErrInc;

    function automatic logic [3:0] popcount(input logic [7:0] k);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, k[i]};
        end
        return n;
    endfunction

    assign byteSum = byteCnt + {28'h0, popcount(in_axis_tkeep)};

    assign lenErrInc =
        (isBody && beat && in_axis_tlast && (byteSum != meta.bodyLen)) ||
        (latch2 && in_axis_tlast && (meta.bodyLen != 32'h0));

    // Running byte count of the current body.
    always_ff @(posedge apclk or negedge apresetn) begin
        if (!apresetn) begin
            byteCnt <= '0;
        end else if (latch2) begin
            byteCnt <= '0;
        end else if (isBody && beat) begin
            byteCnt <= byteSum;
        end
    end

    sat_counter #(.W(CNT_W)) uLenErrCnt (
        .apclk    (apclk),
        .apresetn (apresetn),
        .inc      (lenErrInc),
        .value    (len_err_cnt)
    );
`else
    assign len_err_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_bin_req_parser.sv
// Directed bench for mc_bin_req_parser with meta and body scoreboards.
// Expected len_err_cnt follows MC_PARSER_LEN_CHECK_EN.
module tb_mc_bin_req_parser;

    typedef struct {
        logic [7:0]  opc;
        logic [15:0] key;
        logic [7:0]  ext;
        logic [31:0] body;
        logic [31:0] opq;
        logic [63:0] cas;
    } expMetaT;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic [63:0] u;
        logic        l;
    } expBeatT;

    logic        apclk = 1'b0;
    logic        apresetn;
    logic [63:0] in_axis_tdata;
    logic [7:0]  in_axis_tkeep;
    logic [63:0] in_axis_tuser;
    logic        in_axis_tlast;
    logic        in_axis_tvalid;
    logic        in_axis_tready;
    logic [7:0]  meta_opcode;
    logic [15:0] meta_key_len;
    logic [7:0]  meta_ext_len;
    logic [31:0] meta_body_len;
    logic [31:0] meta_opaque;
    logic [63:0] meta_cas;
    logic        meta_valid;
    logic        meta_ready;
    logic [63:0] body_axis_tdata;
    logic [7:0]  body_axis_tkeep;
    logic [63:0] body_axis_tuser;
    logic        body_axis_tlast;
    logic        body_axis_tvalid;
    logic        body_axis_tready;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;
    logic [15:0] len_err_cnt;

    int errors = 0;
    int checks = 0;
    expMetaT metaQ[$];
    expBeatT bodyQ[$];

`ifdef MC_PARSER_LEN_CHECK_EN
    localparam logic [15:0] LEN_ERR_EXP = 16'd1;
`else
    localparam logic [15:0] LEN_ERR_EXP = 16'd0;
`endif

    always #5 apclk = ~apclk;

    mc_bin_req_parser dut (
        .apclk            (apclk),
        .apresetn         (apresetn),
        .in_axis_tdata    (in_axis_tdata),
        .in_axis_tkeep    (in_axis_tkeep),
        .in_axis_tuser    (in_axis_tuser),
        .in_axis_tlast    (in_axis_tlast),
        .in_axis_tvalid   (in_axis_tvalid),
        .in_axis_tready   (in_axis_tready),
        .meta_opcode      (meta_opcode),
        .meta_key_len     (meta_key_len),
        .meta_ext_len     (meta_ext_len),
        .meta_body_len    (meta_body_len),
        .meta_opaque      (meta_opaque),
        .meta_cas         (meta_cas),
        .meta_valid       (meta_valid),
        .meta_ready       (meta_ready),
        .body_axis_tdata  (body_axis_tdata),
        .body_axis_tkeep  (body_axis_tkeep),
        .body_axis_tuser  (body_axis_tuser),
        .body_axis_tlast  (body_axis_tlast),
        .body_axis_tvalid (body_axis_tvalid),
        .body_axis_tready (body_axis_tready),
        .pkt_cnt          (pkt_cnt),
        .drop_cnt         (drop_cnt),
        .len_err_cnt      (len_err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr0(input logic [7:0] magic,
                                         input logic [7:0] opc,
                                         input logic [15:0] key,
                                         input logic [7:0] ext);
        logic [63:0] b;
        b[7:0]   = magic;
        b[15:8]  = opc;
        b[23:16] = key[15:8];
        b[31:24] = key[7:0];
        b[39:32] = ext;
        b[47:40] = 8'h00;
        b[63:48] = 16'h3412;
        return b;
    endfunction

    function automatic logic [63:0] hdr1(input logic [31:0] body,
                                         input logic [31:0] opq);
        logic [63:0] b;
        for (int i = 0; i < 4; i++) begin
            b[8*i +: 8]     = body[31-8*i -: 8];
            b[32+8*i +: 8]  = opq[31-8*i -: 8];
        end
        return b;
    endfunction

    function automatic logic [63:0] hdr2(input logic [63:0] cas);
        logic [63:0] b;
        for (int i = 0; i < 8; i++) begin
            b[8*i +: 8] = cas[63-8*i -: 8];
        end
        return b;
    endfunction

    task automatic sendBeat(input logic [63:0] d, input logic [7:0] k,
                            input logic [63:0] u, input logic l);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        in_axis_tdata  = d;
        in_axis_tkeep  = k;
        in_axis_tuser  = u;
        in_axis_tlast  = l;
        in_axis_tvalid = 1'b1;
        while (!done) begin
            @(negedge apclk);
            if (in_axis_tready) done = 1;
            @(posedge apclk);
            #1;
            n++;
            if (!done && n > 200) begin
                errors++;
                checks++;
                $error("FAIL send_timeout observed=stall expected=accept");
                done = 1;
            end
        end
        in_axis_tvalid = 1'b0;
        in_axis_tlast  = 1'b0;
    endtask

    task automatic sendHdr(input logic [7:0] opc, input logic [15:0] key,
                           input logic [7:0] ext, input logic [31:0] body,
                           input logic [31:0] opq, input logic [63:0] cas,
                           input logic lastOnCas);
        expMetaT m;
        m.opc  = opc;
        m.key  = key;
        m.ext  = ext;
        m.body = body;
        m.opq  = opq;
        m.cas  = cas;
        metaQ.push_back(m);
        sendBeat(hdr0(8'h80, opc, key, ext), 8'hFF, 64'h0, 1'b0);
        sendBeat(hdr1(body, opq), 8'hFF, 64'h0, 1'b0);
        sendBeat(hdr2(cas), 8'hFF, 64'h0, lastOnCas);
    endtask

    function automatic expBeatT mkBeat(input logic [63:0] d,
                                       input logic [7:0] k,
                                       input logic [63:0] u,
                                       input logic l);
        expBeatT b;
        b.d = d;
        b.k = k;
        b.u = u;
        b.l = l;
        return b;
    endfunction

    // Scoreboard: pop expected items on every DUT handshake.
    always @(negedge apclk) begin
        if (apresetn === 1'b1) begin
            if (meta_valid && meta_ready) begin
                checks++;
                assert (metaQ.size() != 0) else begin
                    errors++;
                    $error("FAIL meta_unexpected observed=word expected=none");
                end
                if (metaQ.size() != 0) begin
                    expMetaT m;
                    m = metaQ.pop_front();
                    check("meta_opcode", 64'(meta_opcode), 64'(m.opc));
                    check("meta_key_len", 64'(meta_key_len), 64'(m.key));
                    check("meta_ext_len", 64'(meta_ext_len), 64'(m.ext));
                    check("meta_body_len", 64'(meta_body_len), 64'(m.body));
                    check("meta_opaque", 64'(meta_opaque), 64'(m.opq));
                    check("meta_cas", meta_cas, m.cas);
                end
            end
            if (body_axis_tvalid && body_axis_tready) begin
                checks++;
                assert (bodyQ.size() != 0) else begin
                    errors++;
                    $error("FAIL body_unexpected observed=%h expected=none",
                           body_axis_tdata);
                end
                if (bodyQ.size() != 0) begin
                    expBeatT b;
                    b = bodyQ.pop_front();
                    check("body_tdata", body_axis_tdata, b.d);
                    check("body_tkeep", 64'(body_axis_tkeep), 64'(b.k));
                    check("body_tuser", body_axis_tuser, b.u);
                    check("body_tlast", 64'(body_axis_tlast), 64'(b.l));
                end
            end
        end
    end

    initial begin
        logic pat [4];
        expBeatT bb [4];
        pat[0] = 1'b1;
        pat[1] = 1'b0;
        pat[2] = 1'b0;
        pat[3] = 1'b1;

        apresetn         = 1'b0;
        in_axis_tdata    = '0;
        in_axis_tkeep    = '0;
        in_axis_tuser    = '0;
        in_axis_tlast    = 1'b0;
        in_axis_tvalid   = 1'b0;
        meta_ready       = 1'b1;
        body_axis_tready = 1'b1;
        repeat (3) @(posedge apclk);
        #1;
        check("rst_meta_valid", 64'(meta_valid), 64'd0);
        check("rst_meta_cas", meta_cas, 64'd0);
        check("rst_meta_opaque", 64'(meta_opaque), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_len_err", 64'(len_err_cnt), 64'd0);
        check("rst_body_valid", 64'(body_axis_tvalid), 64'd0);
        apresetn = 1'b1;
        @(posedge apclk);
        #1;

        // GET with a 5-byte key body.
        sendHdr(8'h00, 16'd5, 8'd0, 32'd5, 32'hDEADBEEF, 64'd0, 1'b0);
        bodyQ.push_back(mkBeat(64'h0000006F6C6C6568, 8'h1F, 64'hA5A5, 1'b1));
        sendBeat(64'h0000006F6C6C6568, 8'h1F, 64'hA5A5, 1'b1);
        repeat (2) @(posedge apclk);
        #1;
        check("get_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("get_len_err", 64'(len_err_cnt), 64'd0);

        // Bad magic, four beats, all discarded.
        for (int i = 0; i < 4; i++) begin
            in_axis_tdata  = (i == 0) ? hdr0(8'h81, 8'h01, 16'd3, 8'd0)
                                      : 64'h1111 * (i + 1);
            in_axis_tkeep  = 8'hFF;
            in_axis_tuser  = '0;
            in_axis_tlast  = (i == 3);
            in_axis_tvalid = 1'b1;
            @(negedge apclk);
            check("badmagic_tready", 64'(in_axis_tready), 64'd1);
            @(posedge apclk);
            #1;
        end
        in_axis_tvalid = 1'b0;
        in_axis_tlast  = 1'b0;
        @(posedge apclk);
        #1;
        check("badmagic_drop_cnt", 64'(drop_cnt), 64'd1);
        check("badmagic_meta_valid", 64'(meta_valid), 64'd0);

        // Two-beat runt, then a bodyless request.
        sendBeat(hdr0(8'h80, 8'h01, 16'd4, 8'd8), 8'hFF, 64'h0, 1'b0);
        sendBeat(hdr1(32'd12, 32'h1), 8'hFF, 64'h0, 1'b1);
        @(posedge apclk);
        #1;
        check("runt_drop_cnt", 64'(drop_cnt), 64'd2);
        check("runt_meta_valid", 64'(meta_valid), 64'd0);
        sendHdr(8'h0A, 16'd0, 8'd0, 32'd0, 32'h00C0FFEE,
                64'h0102030405060708, 1'b1);
        repeat (2) @(posedge apclk);
        #1;
        check("after_runt_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // Meta backpressure stalls the next header.
        meta_ready = 1'b0;
        sendHdr(8'h01, 16'd1, 8'd0, 32'd0, 32'h000000AA, 64'h11, 1'b1);
        fork
            sendHdr(8'h02, 16'd2, 8'd0, 32'd0, 32'h000000BB, 64'h22, 1'b1);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge apclk);
                    check("stall_tready", 64'(in_axis_tready), 64'd0);
                    @(posedge apclk);
                    #1;
                end
                check("stall_opaque_a", 64'(meta_opaque), 64'hAA);
                meta_ready = 1'b1;
                @(posedge apclk);
                #1;
                meta_ready = 1'b0;
                repeat (5) @(posedge apclk);
                #1;
                check("stall_valid_b", 64'(meta_valid), 64'd1);
                check("stall_opaque_b", 64'(meta_opaque), 64'hBB);
                meta_ready = 1'b1;
            end
        join
        repeat (2) @(posedge apclk);
        #1;
        check("stall_pkt_cnt", 64'(pkt_cnt), 64'd4);
        check("stall_meta_drained", 64'(meta_valid), 64'd0);

        // Four-beat body under toggling body backpressure.
        sendHdr(8'h01, 16'd8, 8'd8, 32'd32, 32'h12345678,
                64'hCAFEF00D00000001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bb[i] = mkBeat(64'h0101010101010101 * (i + 3), 8'hFF,
                           64'(i + 100), (i == 3));
            bodyQ.push_back(bb[i]);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    sendBeat(bb[i].d, bb[i].k, bb[i].u, bb[i].l);
                end
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    body_axis_tready = pat[i];
                    @(negedge apclk);
                    check("bp_tready_mirror", 64'(in_axis_tready),
                          64'(pat[i]));
                    @(posedge apclk);
                    #1;
                end
                body_axis_tready = 1'b1;
            end
        join
        repeat (2) @(posedge apclk);
        #1;
        check("bp_pkt_cnt", 64'(pkt_cnt), 64'd5);
        check("bp_len_err", 64'(len_err_cnt), 64'd0);

        // Body shorter than advertised: 12 of 16 bytes.
        sendHdr(8'h01, 16'd4, 8'd0, 32'd16, 32'h0BADF00D, 64'h0, 1'b0);
        bodyQ.push_back(mkBeat(64'h8877665544332211, 8'hFF, 64'h5, 1'b0));
        bodyQ.push_back(mkBeat(64'h00000000CCBBAA99, 8'h0F, 64'h6, 1'b1));
        sendBeat(64'h8877665544332211, 8'hFF, 64'h5, 1'b0);
        sendBeat(64'h00000000CCBBAA99, 8'h0F, 64'h6, 1'b1);
        repeat (2) @(posedge apclk);
        #1;
        check("short_len_err", 64'(len_err_cnt), 64'(LEN_ERR_EXP));
        check("short_pkt_cnt", 64'(pkt_cnt), 64'd6);
        check("final_drop_cnt", 64'(drop_cnt), 64'd2);

        repeat (4) @(posedge apclk);
        #1;
        check("meta_queue_empty", 64'(metaQ.size()), 64'd0);
        check("body_queue_empty", 64'(bodyQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
